// File: rtl/store_sb_pkg.sv
// Shared state encodings, fail codes and width helper for the store-bus scoreboard.
package store_sb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PASS = 2'd2;
  localparam logic [1:0] ST_FAIL = 2'd3;

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_DATA    = 3'd1;
  localparam logic [2:0] FC_ADDR    = 3'd2;
  localparam logic [2:0] FC_DUP     = 3'd3;
  localparam logic [2:0] FC_TIMEOUT = 3'd4;
  localparam logic [2:0] FC_CFG     = 3'd5;

  // Never returns 0 so single-entry tables still get a legal 1-bit index.
  function automatic int sb_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/store_sb_lookup.sv
// Combinational compare of one store against the expected and ignore tables.
// Zero latency, no flow control; the caller applies match precedence.
module store_sb_lookup
  import store_sb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_EXP  = 4,
  parameter int NUM_IGN  = 2,
  parameter int IN_ORDER = 1,
  localparam int IDX_W   = sb_clog2(NUM_EXP),
  localparam int PTR_W   = sb_clog2(NUM_EXP + 1)
) (
  input  logic [ADDR_W-1:0]               addr,
  input  logic [DATA_W-1:0]               data,
  input  logic [NUM_EXP-1:0][ADDR_W-1:0]  exp_addr,
  input  logic [NUM_EXP-1:0][DATA_W-1:0]  exp_data,
  input  logic [NUM_EXP-1:0]              exp_valid,
  input  logic [NUM_EXP-1:0]              exp_matched,
  input  logic [PTR_W-1:0]                exp_ptr,
  input  logic [NUM_IGN-1:0][ADDR_W-1:0]  ign_addr,
  input  logic [NUM_IGN-1:0]              ign_valid,
  output logic                            hit,
  output logic [IDX_W-1:0]                hit_idx,
  output logic                            data_mismatch,
  output logic                            duplicate,
  output logic                            ignore_hit
);

  logic [NUM_EXP-1:0] elig;
  logic [NUM_EXP-1:0] a_eq;
  logic [NUM_EXP-1:0] d_eq;
  logic [NUM_IGN-1:0] ign_eq;

  for (genvar i = 0; i < NUM_EXP; i++) begin : g_exp
    assign a_eq[i] = (exp_addr[i] == addr);
    assign d_eq[i] = (exp_data[i] == data);
    // In-order mode only the entry at exp_ptr may match; otherwise any unmatched one.
    assign elig[i] = exp_valid[i] &&
                     ((IN_ORDER != 0) ? (exp_ptr == PTR_W'(i)) : !exp_matched[i]);
  end

  for (genvar j = 0; j < NUM_IGN; j++) begin : g_ign
    assign ign_eq[j] = ign_valid[j] && (ign_addr[j] == addr);
  end

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_EXP - 1; i >= 0; i--) begin
      if (elig[i] && a_eq[i] && d_eq[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign data_mismatch = |(elig & a_eq & ~d_eq);
  assign duplicate     = (IN_ORDER == 0) && (|(exp_valid & exp_matched & a_eq));
  assign ignore_hit    = |ign_eq;

endmodule

// File: rtl/store_scoreboard.sv
// Store-bus scoreboard: programmable expected/ignore tables, FSM and counters.
// Each store is judged at its edge with results one cycle later; the core bus is never stalled.
module store_scoreboard
  import store_sb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_EXP  = 4,
  parameter int NUM_IGN  = 2,
  parameter int TIMEOUT  = 1000,
  parameter int IN_ORDER = 1,
  localparam int CFG_W   = sb_clog2((NUM_EXP > NUM_IGN) ? NUM_EXP : NUM_IGN),
  localparam int CNT_W   = sb_clog2(NUM_EXP + 1),
  localparam int IDX_W   = sb_clog2(NUM_EXP)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic              cfg_kind,
  input  logic [CFG_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  input  logic              start,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] data_adr,
  input  logic [DATA_W-1:0] write_data,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [2:0]        fail_code,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [15:0]       ign_cnt,
  output logic [31:0]       cycle_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  logic [1:0]                      state;
  logic [NUM_EXP-1:0][ADDR_W-1:0]  exp_addr_q;
  logic [NUM_EXP-1:0][DATA_W-1:0]  exp_data_q;
  logic [NUM_EXP-1:0]              exp_valid_q, exp_valid_nxt, matched_q;
  logic [NUM_IGN-1:0][ADDR_W-1:0]  ign_addr_q;
  logic [NUM_IGN-1:0]              ign_valid_q, ign_valid_nxt;
  logic [CNT_W-1:0]                exp_ptr, n_valid;
  logic [NUM_EXP:0]                v_ext;
  logic                            cfg_ok, cfg_bad, store_x, final_hit, timeout_hit;
  logic [31:0]                     cyc_next;
  logic                            hit, data_mismatch, duplicate, ignore_hit;
  logic [IDX_W-1:0]                hit_idx;

  assign cfg_ok = cfg_we && (state == ST_IDLE);

  // Valid bits as they will be after this edge, so a start alongside a write sees it.
  always_comb begin
    exp_valid_nxt = exp_valid_q;
    ign_valid_nxt = ign_valid_q;
    for (int i = 0; i < NUM_EXP; i++)
      if (cfg_ok && !cfg_kind && (cfg_idx == CFG_W'(i))) exp_valid_nxt[i] = cfg_valid;
    for (int j = 0; j < NUM_IGN; j++)
      if (cfg_ok && cfg_kind && (cfg_idx == CFG_W'(j))) ign_valid_nxt[j] = cfg_valid;
  end

  // In-order tables must be a solid run of valid entries starting at index 0.
  assign v_ext   = {1'b0, exp_valid_nxt};
  assign cfg_bad = (exp_valid_nxt == '0) ||
                   ((IN_ORDER != 0) && ((v_ext & (v_ext + (NUM_EXP + 1)'(1))) != '0));

  always_comb begin
    n_valid = '0;
    for (int i = 0; i < NUM_EXP; i++)
      if (exp_valid_q[i]) n_valid = n_valid + CNT_W'(1);
  end

`ifdef SYNTHESIS
  assign store_x = 1'b0;
`else
  assign store_x = $isunknown({data_adr, write_data});
`endif

  store_sb_lookup #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .NUM_EXP (NUM_EXP),
    .NUM_IGN (NUM_IGN), .IN_ORDER (IN_ORDER)
  ) u_lookup (
    .addr          (data_adr),
    .data          (write_data),
    .exp_addr      (exp_addr_q),
    .exp_data      (exp_data_q),
    .exp_valid     (exp_valid_q),
    .exp_matched   (matched_q),
    .exp_ptr       (exp_ptr),
    .ign_addr      (ign_addr_q),
    .ign_valid     (ign_valid_q),
    .hit           (hit),
    .hit_idx       (hit_idx),
    .data_mismatch (data_mismatch),
    .duplicate     (duplicate),
    .ignore_hit    (ignore_hit)
  );

  assign final_hit   = mem_write && !store_x && hit && ((match_cnt + CNT_W'(1)) == n_valid);
  assign cyc_next    = (cycle_cnt == 32'hFFFF_FFFF) ? cycle_cnt : cycle_cnt + 32'd1;
  assign timeout_hit = (cyc_next >= 32'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      exp_valid_q <= '0;
      ign_valid_q <= '0;
      matched_q   <= '0;
      exp_ptr     <= '0;
      match_cnt   <= '0;
      ign_cnt     <= '0;
      cycle_cnt   <= '0;
      fail_code   <= FC_NONE;
      fail_addr   <= '0;
      fail_data   <= '0;
    end else begin
      exp_valid_q <= exp_valid_nxt;
      ign_valid_q <= ign_valid_nxt;
      for (int i = 0; i < NUM_EXP; i++)
        if (cfg_ok && !cfg_kind && (cfg_idx == CFG_W'(i))) begin
          exp_addr_q[i] <= cfg_addr;
          exp_data_q[i] <= cfg_data;
        end
      for (int j = 0; j < NUM_IGN; j++)
        if (cfg_ok && cfg_kind && (cfg_idx == CFG_W'(j))) ign_addr_q[j] <= cfg_addr;

      case (state)
        ST_RUN: begin
          cycle_cnt <= cyc_next;
          if (mem_write && (store_x || !hit)) begin
            if (!store_x && !data_mismatch && !duplicate && ignore_hit) begin
              ign_cnt <= (ign_cnt == 16'hFFFF) ? ign_cnt : ign_cnt + 16'd1;
              if (timeout_hit) begin
                state     <= ST_FAIL;
                fail_code <= FC_TIMEOUT;
              end
            end else begin
              state     <= ST_FAIL;
              fail_addr <= data_adr;
              fail_data <= write_data;
              fail_code <= store_x       ? FC_ADDR :
                           data_mismatch ? FC_DATA :
                           duplicate     ? FC_DUP  : FC_ADDR;
            end
          end else begin
            if (mem_write) begin
              matched_q[hit_idx] <= 1'b1;
              match_cnt          <= match_cnt + CNT_W'(1);
              if (IN_ORDER != 0) exp_ptr <= exp_ptr + CNT_W'(1);
            end
            if (final_hit) begin
              state <= ST_PASS;
            end else if (timeout_hit) begin
              state     <= ST_FAIL;
              fail_code <= FC_TIMEOUT;
            end
          end
        end
        default: begin
          if (start) begin
            matched_q <= '0;
            exp_ptr   <= '0;
            match_cnt <= '0;
            ign_cnt   <= '0;
            cycle_cnt <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            state     <= cfg_bad ? ST_FAIL : ST_RUN;
            fail_code <= cfg_bad ? FC_CFG : FC_NONE;
          end
        end
      endcase
    end
  end

  assign done = (state == ST_PASS) || (state == ST_FAIL);
  assign pass = (state == ST_PASS);
  assign fail = (state == ST_FAIL);

endmodule

// File: tb/tb_store_scoreboard.sv
// Directed bench for store_scoreboard: one in-order and one any-order instance, queue scoreboard.
module tb_store_scoreboard;
  import store_sb_pkg::*;

  typedef struct packed {
    logic        done, pass, fail;
    logic [2:0]  code;
    logic [2:0]  mcnt;
    logic [15:0] icnt;
    logic [31:0] faddr, fdata;
  } obs_t;

  typedef struct {
    int    dut;
    string tag;
    obs_t  v;
  } exp_t;

  logic        clk, reset, cfg_we, cfg_kind, cfg_valid, start0, start1, mem_write;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_addr, cfg_data, data_adr, write_data;

  logic        done0, pass0, fail0, done1, pass1, fail1;
  logic [2:0]  fc0, fc1, mc0, mc1;
  logic [15:0] ic0, ic1;
  logic [31:0] cc0, cc1, fa0, fa1, fd0, fd1;
  obs_t        obs0, obs1;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  store_scoreboard #(.ADDR_W(32), .DATA_W(32), .NUM_EXP(4), .NUM_IGN(2),
                     .TIMEOUT(20), .IN_ORDER(1)) u_ord (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_kind(cfg_kind), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_valid(cfg_valid), .start(start0),
    .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
    .done(done0), .pass(pass0), .fail(fail0), .fail_code(fc0), .match_cnt(mc0),
    .ign_cnt(ic0), .cycle_cnt(cc0), .fail_addr(fa0), .fail_data(fd0));

  store_scoreboard #(.ADDR_W(32), .DATA_W(32), .NUM_EXP(4), .NUM_IGN(2),
                     .TIMEOUT(20), .IN_ORDER(0)) u_any (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_kind(cfg_kind), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_valid(cfg_valid), .start(start1),
    .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
    .done(done1), .pass(pass1), .fail(fail1), .fail_code(fc1), .match_cnt(mc1),
    .ign_cnt(ic1), .cycle_cnt(cc1), .fail_addr(fa1), .fail_data(fd1));

  assign obs0 = {done0, pass0, fail0, fc0, mc0, ic0, fa0, fd0};
  assign obs1 = {done1, pass1, fail1, fc1, mc1, ic1, fa1, fd1};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push(input int dut, input string tag, input logic p, input logic f,
                      input logic [2:0] code, input int mcnt, input int icnt,
                      input logic [31:0] fa, input logic [31:0] fd);
    exp_t e;
    e.dut    = dut;
    e.tag    = tag;
    e.v.done = p | f;
    e.v.pass = p;
    e.v.fail = f;
    e.v.code = code;
    e.v.mcnt = 3'(mcnt);
    e.v.icnt = 16'(icnt);
    e.v.faddr = fa;
    e.v.fdata = fd;
    sbq.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    obs_t o;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_bad++;
      $display("FAIL sb_empty observed=no expectation required=one queued");
      return;
    end
    e = sbq.pop_front();
    o = (e.dut == 0) ? obs0 : obs1;
    assert (o === e.v) else begin
      n_bad++;
      $error("FAIL %s observed=%h required=%h", e.tag, o, e.v);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] o, input logic [31:0] x);
    n_cmp++;
    assert (o === x) else begin
      n_bad++;
      $error("FAIL %s observed=%0d required=%0d", tag, o, x);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic cfg(input logic kind, input int idx, input int a, input int d, input logic v);
    cfg_we = 1'b1; cfg_kind = kind; cfg_idx = 2'(idx);
    cfg_addr = 32'(a); cfg_data = 32'(d); cfg_valid = v;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic arm(input int dut);
    if (dut == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic store(input int a, input int d);
    mem_write = 1'b1; data_adr = 32'(a); write_data = 32'(d);
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  initial begin
    reset = 1'b0; cfg_we = 1'b0; cfg_kind = 1'b0; cfg_idx = '0; cfg_addr = '0;
    cfg_data = '0; cfg_valid = 1'b0; start0 = 1'b0; start1 = 1'b0;
    mem_write = 1'b0; data_adr = '0; write_data = '0;
    repeat (2) @(negedge clk);
    push(0, "reset_ord", 0, 0, FC_NONE, 0, 0, 0, 0); check_pop();
    push(1, "reset_any", 0, 0, FC_NONE, 0, 0, 0, 0); check_pop();
    chk32("reset_cycle_cnt", cc0, 0);
    reset = 1'b1;

    // Single-store pass with one ignored store ahead of it.
    cfg(0, 0, 100, 25, 1);
    cfg(1, 0, 96, 0, 1);
    arm(0);
    store(96, 7);
    push(0, "ignored_store", 0, 0, FC_NONE, 0, 1, 0, 0); check_pop();
    store(100, 25);
    push(0, "single_pass", 1, 0, FC_NONE, 1, 1, 0, 0); check_pop();
    chk32("pass_cycle_cnt", cc0, 2);
    store(100, 99);
    push(0, "pass_sticky", 1, 0, FC_NONE, 1, 1, 0, 0); check_pop();
    chk32("pass_cnt_frozen", cc0, 2);

    // Re-arm with the retained table, then a data mismatch.
    arm(0);
    store(100, 24);
    push(0, "data_mismatch", 0, 1, FC_DATA, 0, 0, 100, 24); check_pop();

    // Any-order: duplicate, then re-arm and complete out of index order.
    do_reset();
    cfg(0, 0, 100, 25, 1);
    cfg(0, 1, 104, 9, 1);
    arm(1);
    store(104, 9);
    push(1, "any_first", 0, 0, FC_NONE, 1, 0, 0, 0); check_pop();
    store(104, 9);
    push(1, "any_duplicate", 0, 1, FC_DUP, 1, 0, 104, 9); check_pop();
    arm(1);
    store(104, 9);
    store(100, 25);
    push(1, "any_order_pass", 1, 0, FC_NONE, 2, 0, 0, 0); check_pop();

    // Timeout exactly on the 20th RUN cycle.
    do_reset();
    cfg(0, 0, 100, 25, 1);
    arm(0);
    repeat (19) @(negedge clk);
    push(0, "pre_timeout", 0, 0, FC_NONE, 0, 0, 0, 0); check_pop();
    chk32("pre_timeout_cnt", cc0, 19);
    @(negedge clk);
    push(0, "timeout", 0, 1, FC_TIMEOUT, 0, 0, 0, 0); check_pop();
    chk32("timeout_cnt", cc0, 20);
    arm(0);
    repeat (19) @(negedge clk);
    store(100, 25);
    push(0, "final_on_timeout", 1, 0, FC_NONE, 1, 0, 0, 0); check_pop();
    chk32("final_on_timeout_cnt", cc0, 20);

    // In-order violation.
    do_reset();
    cfg(0, 0, 100, 1, 1);
    cfg(0, 1, 104, 2, 1);
    arm(0);
    store(104, 2);
    push(0, "order_violation", 0, 1, FC_ADDR, 0, 0, 104, 2); check_pop();

    // Config errors: empty table, and a gap in the in-order table.
    do_reset();
    arm(0);
    push(0, "cfg_empty", 0, 1, FC_CFG, 0, 0, 0, 0); check_pop();
    do_reset();
    cfg(0, 1, 104, 2, 1);
    arm(0);
    push(0, "cfg_gap_in_order", 0, 1, FC_CFG, 0, 0, 0, 0); check_pop();
    arm(1);
    store(104, 2);
    push(1, "gap_ok_any_order", 1, 0, FC_NONE, 1, 0, 0, 0); check_pop();
    push(0, "fail_sticky", 0, 1, FC_CFG, 0, 0, 0, 0); check_pop();

    // Write and start in the same cycle: start sees the new entry.
    do_reset();
    cfg_we = 1'b1; cfg_kind = 1'b0; cfg_idx = 2'd0; cfg_addr = 32'd100;
    cfg_data = 32'd25; cfg_valid = 1'b1; start0 = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; start0 = 1'b0;
    push(0, "cfg_with_start", 0, 0, FC_NONE, 0, 0, 0, 0); check_pop();

    // Config write during RUN must not disturb the table.
    cfg(0, 0, 200, 5, 1);
    store(100, 25);
    push(0, "cfg_in_run_ignored", 1, 0, FC_NONE, 1, 0, 0, 0); check_pop();

    // Reset mid-run clears outputs and tables.
    arm(0);
    @(negedge clk);
    do_reset();
    push(0, "midrun_reset", 0, 0, FC_NONE, 0, 0, 0, 0); check_pop();
    chk32("midrun_reset_cnt", cc0, 0);
    arm(0);
    push(0, "tables_cleared", 0, 1, FC_CFG, 0, 0, 0, 0); check_pop();

    chk32("queue_drained", 32'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
